fk_history_seq: RTL and testbench
=================================

FK_HISTORY_SEQ -- requirements
Module: fk_history_seq

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 sample_in  input  25  new filter sample, signed two's complement.
REQ-004 sample_valid  input  1  sample_in valid this cycle.
REQ-005 ovr_clr  input  1  synchronous clear of the overrun flag.
REQ-006 ready  output  1  block can accept a sample this cycle.
REQ-007 fk, fk_1, fk_2  output  25 each  current, one-back and two-back samples, fed to the tap selector.
REQ-008 select  output  2  tap-select code for the downstream selector: 00=fk, 01=fk_1, 10=fk_2, 11=idle (selector outputs 0).
REQ-009 mac_en  output  1  downstream accumulator adds the selected tap this cycle.
REQ-010 acc_clr  output  1  downstream accumulator loads rather than adds this cycle.
REQ-011 done  output  1  one-cycle pulse: tap sequence for the current sample complete.
REQ-012 overrun  output  1  sticky flag: a sample was offered while not ready.

Function
REQ-013 FSM states SHALL be IDLE, TAP0, TAP1, TAP2, DONE; IDLE is the only state with ready=1.
REQ-014 In IDLE with sample_valid=1, at the clock edge: fk<=sample_in, fk_1<=fk (old), fk_2<=fk_1 (old); state->TAP0.
REQ-015 In IDLE with sample_valid=0: history unchanged; state stays IDLE.
REQ-016 TAP0: select=00, mac_en=1, acc_clr=1; next TAP1.
REQ-017 TAP1: select=01, mac_en=1, acc_clr=0; next TAP2.
REQ-018 TAP2: select=10, mac_en=1, acc_clr=0; next DONE.
REQ-019 DONE: select=11, mac_en=0, done=1; next IDLE unconditionally.
REQ-020 IDLE: select=11, mac_en=0, acc_clr=0, done=0.
REQ-021 ready, select, mac_en, acc_clr and done SHALL be decoded from the registered state only, with no combinational path from any input.
REQ-022 Latency: sample accepted at edge E; TAP0 is active in the cycle after E; done is high in the 4th cycle after E; maximum throughput is one sample per 5 cycles.
REQ-023 A sample_valid in any state other than IDLE SHALL be dropped: history and FSM unaffected.
REQ-024 History SHALL be copied bit-exact, with no sign extension, rounding or saturation.
REQ-025 fk, fk_1 and fk_2 SHALL hold stable in every state other than the IDLE-accept edge.

Reset
REQ-026 While reset=1, asynchronously: state=IDLE; fk=fk_1=fk_2=0; select=11; mac_en=0; acc_clr=0; done=0; overrun=0; ready=1.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence with no done pulse; the first accept after release shifts into zeroed history.

Configuration
REQ-028 With macro FK_OVERRUN_FLAG_EN defined: overrun sets to 1 on the edge where sample_valid=1 and ready=0.
REQ-029 With FK_OVERRUN_FLAG_EN defined: overrun clears on an edge with ovr_clr=1; if set and clear occur in the same cycle, set wins.
REQ-030 Without FK_OVERRUN_FLAG_EN: overrun is constant 0, ovr_clr is ignored, and no flag register exists.

Verification
REQ-031 Reset, then send samples 0x0000005, then 0x1FFFFFF (-1), then 0x0000003 (each in IDLE) -> fk=3, fk_1=0x1FFFFFF, fk_2=5.
REQ-032 Single sample at edge E -> select sequence 00,01,10,11 in cycles E+1..E+4; mac_en=1 for 3 cycles; acc_clr only at E+1; done only at E+4.
REQ-033 sample_valid held high continuously -> accepts exactly every 5 cycles; the offers made in TAP0..DONE are dropped; with FK_OVERRUN_FLAG_EN, overrun=1 after the first drop.
REQ-034 With FK_OVERRUN_FLAG_EN: ovr_clr=1 in the same cycle as a drop -> overrun remains 1; ovr_clr alone in the next cycle -> overrun=0.
REQ-035 reset pulsed during TAP1 -> outputs go to reset values immediately; no done pulse; history reads 0.

Source files
------------

// File: rtl/fk_history_seq_if.sv
// fk_history_seq_if: sample input, tap-select and status bundle for fk_history_seq.
interface fk_history_seq_if;
  logic [24:0] sample_in;
  logic        sample_valid;
  logic        ovr_clr;
  logic        ready;
  logic [24:0] fk;
  logic [24:0] fk_1;
  logic [24:0] fk_2;
  logic [1:0]  select;
  logic        mac_en;
  logic        acc_clr;
  logic        done;
  logic        overrun;
  modport slave (
    input  sample_in, sample_valid, ovr_clr,
    output ready, fk, fk_1, fk_2, select, mac_en, acc_clr, done, overrun
  );
  modport master (
    output sample_in, sample_valid, ovr_clr,
    input  ready, fk, fk_1, fk_2, select, mac_en, acc_clr, done, overrun
  );
endinterface

// File: rtl/fk_history_seq.sv
// fk_history_seq: three-deep sample history with a 3-tap MAC sequencer.
// Define FK_OVERRUN_FLAG_EN to build the sticky overrun flag.
module fk_history_seq (
  input logic         clk,
  input logic         reset,
  fk_history_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TAP0, TAP1, TAP2, DONE} state_t;
  state_t      state_q, state_d;
  logic [24:0] fk_q, fk1_q, fk2_q;
  logic        accept;
  logic [1:0]  select;
  logic        mac_en, acc_clr, done;
  assign accept = (state_q == IDLE) && bus.sample_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fk_q    <= '0;
      fk1_q   <= '0;
      fk2_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fk_q  <= bus.sample_in;
        fk1_q <= fk_q;
        fk2_q <= fk1_q;
      end
    end
  end
  // Outputs come from state_q alone so nothing downstream sees an input-to-output path.
  always_comb begin
    state_d = state_q;
    select  = 2'b11;
    mac_en  = 1'b0;
    acc_clr = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: state_d = bus.sample_valid ? TAP0 : IDLE;
      TAP0: begin state_d = TAP1; select = 2'b00; mac_en = 1'b1; acc_clr = 1'b1; end
      TAP1: begin state_d = TAP2; select = 2'b01; mac_en = 1'b1; end
      TAP2: begin state_d = DONE; select = 2'b10; mac_en = 1'b1; end
      DONE: begin state_d = IDLE; done = 1'b1; end
      default: state_d = IDLE;
    endcase
  end
  assign bus.ready   = state_q == IDLE;
  assign bus.select  = select;
  assign bus.mac_en  = mac_en;
  assign bus.acc_clr = acc_clr;
  assign bus.done    = done;
  assign bus.fk      = fk_q;
  assign bus.fk_1    = fk1_q;
  assign bus.fk_2    = fk2_q;
`ifdef FK_OVERRUN_FLAG_EN
  logic ovr_q;
  // Set takes priority over clear so a drop coinciding with a clear is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovr_q <= 1'b0;
    else if (bus.sample_valid && state_q != IDLE) ovr_q <= 1'b1;
    else if (bus.ovr_clr) ovr_q <= 1'b0;
  end
  assign bus.overrun = ovr_q;
`else
  assign bus.overrun = 1'b0;
`endif
endmodule

// File: tb/tb_fk_history_seq.sv
// tb_fk_history_seq: directed stimulus against a cycle-count model of the tap sequencer.
module tb_fk_history_seq;
  logic clk = 0;
  logic reset = 1;
  int   errors = 0;
  int   checks = 0;
  fk_history_seq_if bus();
  fk_history_seq dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // Model: history as an array, sequencing as "cycles since accept" (0 = idle).
  logic [24:0] hist [3];
  int          phase = 0;
  logic        m_ovr = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      phase = 0;
      m_ovr = 0;
    end else begin
`ifdef FK_OVERRUN_FLAG_EN
      if (bus.sample_valid && phase != 0) m_ovr = 1;
      else if (bus.ovr_clr) m_ovr = 0;
`endif
      if (phase == 0) begin
        if (bus.sample_valid) begin
          hist[2] = hist[1];
          hist[1] = hist[0];
          hist[0] = bus.sample_in;
          phase = 1;
        end
      end else phase = (phase == 4) ? 0 : phase + 1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("ready", 32'(bus.ready), 32'(phase == 0));
    chk("select", 32'(bus.select), (phase >= 1 && phase <= 3) ? 32'(phase - 1) : 32'd3);
    chk("mac_en", 32'(bus.mac_en), 32'(phase >= 1 && phase <= 3));
    chk("acc_clr", 32'(bus.acc_clr), 32'(phase == 1));
    chk("done", 32'(bus.done), 32'(phase == 4));
    chk("fk", 32'(bus.fk), 32'(hist[0]));
    chk("fk_1", 32'(bus.fk_1), 32'(hist[1]));
    chk("fk_2", 32'(bus.fk_2), 32'(hist[2]));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
  end
  // Offer one sample from IDLE and return once the FSM is back in IDLE.
  task automatic send(input logic [24:0] v);
    bus.sample_in = v;
    bus.sample_valid = 1;
    @(negedge clk);
    bus.sample_valid = 0;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    bus.sample_in = '0;
    bus.sample_valid = 0;
    bus.ovr_clr = 0;
    #1;
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_select", 32'(bus.select), 32'd3);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    send(25'h0000005);
    send(25'h1FFFFFF);
    send(25'h0000003);
    chk("hist_fk", 32'(bus.fk), 32'h3);
    chk("hist_fk_1", 32'(bus.fk_1), 32'h1FFFFFF);
    chk("hist_fk_2", 32'(bus.fk_2), 32'h5);
    // Tap timing pinned by literals: E+1..E+4.
    bus.sample_in = 25'h1000000;
    bus.sample_valid = 1;
    @(negedge clk);
    bus.sample_valid = 0;
    chk("lat_sel0", 32'(bus.select), 32'd0);
    chk("lat_clr0", 32'(bus.acc_clr), 32'd1);
    @(negedge clk);
    chk("lat_sel1", 32'(bus.select), 32'd1);
    chk("lat_clr1", 32'(bus.acc_clr), 32'd0);
    @(negedge clk);
    chk("lat_sel2", 32'(bus.select), 32'd2);
    chk("lat_mac2", 32'(bus.mac_en), 32'd1);
    @(negedge clk);
    chk("lat_sel3", 32'(bus.select), 32'd3);
    chk("lat_done", 32'(bus.done), 32'd1);
    chk("lat_mac3", 32'(bus.mac_en), 32'd0);
    @(negedge clk);
    chk("lat_idle_done", 32'(bus.done), 32'd0);
    chk("neg_boundary", 32'(bus.fk), 32'h1000000);
    send(25'h0FFFFFF);
    // Continuous offers: only every fifth is accepted.
    bus.sample_valid = 1;
    for (int i = 0; i < 16; i++) begin
      bus.sample_in = 25'(i * 32'h12345 + 1);
      @(negedge clk);
    end
    bus.sample_valid = 0;
    chk("stream_fk", 32'(bus.fk), 32'(25'(15 * 32'h12345 + 1)));
    chk("stream_fk_1", 32'(bus.fk_1), 32'(25'(10 * 32'h12345 + 1)));
    repeat (4) @(negedge clk);
    // Drop with a simultaneous clear, then a clear alone.
    bus.sample_in = 25'h0000011;
    bus.sample_valid = 1;
    @(negedge clk);
    bus.sample_in = 25'h0000022;
    bus.ovr_clr = 1;
    @(negedge clk);
    bus.sample_valid = 0;
    @(negedge clk);
    bus.ovr_clr = 0;
    repeat (3) @(negedge clk);
    chk("drop_fk", 32'(bus.fk), 32'h11);
    // Reset pulse in TAP1 aborts the sequence.
    bus.sample_in = 25'h0000077;
    bus.sample_valid = 1;
    @(negedge clk);
    bus.sample_valid = 0;
    @(negedge clk);
    chk("pre_abort_sel", 32'(bus.select), 32'd1);
    #2 reset = 1;
    #1;
    chk("abort_sel", 32'(bus.select), 32'd3);
    chk("abort_mac", 32'(bus.mac_en), 32'd0);
    chk("abort_fk", 32'(bus.fk), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    send(25'h0000009);
    chk("post_fk", 32'(bus.fk), 32'h9);
    chk("post_fk_1", 32'(bus.fk_1), 32'h0);
    chk("post_fk_2", 32'(bus.fk_2), 32'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
